// File: rtl/call_return_stack_pkg.sv
// Constants shared by the pipeline top, fetch stage and return-address stack.
// Also holds the decoded stack-operation encoding.
package call_return_stack_pkg;

   localparam int PC_WIDTH  = 12;
   localparam int RAS_DEPTH = 8;

   typedef enum logic [1:0] {
      RAS_IDLE    = 2'd0,
      RAS_PUSH    = 2'd1,
      RAS_POP     = 2'd2,
      RAS_REPLACE = 2'd3
   } rasOp_e;

   function automatic rasOp_e decodeOp(input logic push, input logic pop);
      rasOp_e op;
      op = RAS_IDLE;
      if (push && pop)  op = RAS_REPLACE;
      else if (push)    op = RAS_PUSH;
      else if (pop)     op = RAS_POP;
      return op;
   endfunction

endpackage

// File: rtl/call_return_stack.sv
// Return-address stack written from decode; top-of-stack and status are combinational from state.
// Updates land on the clock edge with enb=1; enb=0 (stall) freezes all state.
module call_return_stack
   import call_return_stack_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH,
   parameter int WIDTH = PC_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enb,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           pushData,
   output logic [WIDTH-1:0]           stackOut,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SPW-1:0]   sp;
   logic [SPW-1:0]   spMinus1;
   logic [IW-1:0]    topIdx;
   logic [IW-1:0]    nextIdx;
   rasOp_e           op;

   assign op       = decodeOp(push, pop);
   assign spMinus1 = sp - SPW'(1);
   assign topIdx   = spMinus1[IW-1:0];
   assign nextIdx  = sp[IW-1:0];

   assign empty    = (sp == '0);
   assign full     = (sp == SPW'(DEPTH));
   assign depth    = sp;
   assign stackOut = empty ? '0 : mem[topIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enb) begin
         unique case (op)
            RAS_PUSH: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  mem[nextIdx] <= pushData;
                  sp           <= sp + SPW'(1);
               end
            end
            RAS_POP: begin
               // Popped entry is left stale in mem; only sp moves.
               if (empty) underflow <= 1'b1;
               else       sp        <= spMinus1;
            end
            RAS_REPLACE: begin
               // Return followed by call overwrites the top; on empty it degrades to a push.
               if (empty) begin
                  underflow <= 1'b1;
                  mem[0]    <= pushData;
                  sp        <= SPW'(1);
               end else begin
                  mem[topIdx] <= pushData;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
